// File: rtl/demux_reg_n.sv
// demux_reg_n: 1-to-N registered demultiplexer with manual select and auto-scan routing
module demux_reg_n #(
  parameter int W    = 4,
  parameter int N    = 8,
  parameter int SELW = 3,
  parameter bit HOLD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    din,
  input  logic [SELW-1:0] sel,
  input  logic            en,
  input  logic            auto,
  output logic [N*W-1:0]  dout,
  output logic [N-1:0]    dvalid,
  output logic [SELW-1:0] cur_ch,
  output logic            wrap,
  output logic            sel_err
);
  logic [SELW-1:0] scan_ptr, ptr_nxt, tgt;
  logic            sel_ok, hit, last;
  // routing target, write qualifier and scan pointer successor
  always_comb begin
    sel_ok  = {1'b0, sel} < (SELW+1)'(N);
    tgt     = auto ? scan_ptr : sel;
    hit     = en && (auto || sel_ok);
    last    = scan_ptr == SELW'(N-1);
    ptr_nxt = last ? '0 : scan_ptr + 1'b1;
  end
  // channel registers, strobes and scan pointer state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout     <= '0;
      dvalid   <= '0;
      cur_ch   <= '0;
      wrap     <= 1'b0;
      sel_err  <= 1'b0;
      scan_ptr <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        dout[k*W +: W] <= (hit && tgt == SELW'(k)) ? din : (HOLD ? dout[k*W +: W] : '0);
        dvalid[k]      <= hit && tgt == SELW'(k);
      end
      cur_ch   <= hit ? tgt : cur_ch;
      wrap     <= en && auto && last;
      sel_err  <= en && !auto && !sel_ok;
      scan_ptr <= (en && auto) ? ptr_nxt : scan_ptr;
    end
endmodule

// File: tb/tb_demux_reg_n.sv
// tb_demux_reg_n: randomized and directed checks of three demux_reg_n configurations against a reference model
module tb_demux_reg_n;
  logic clk = 0, rst = 1, en = 0, auto = 0;
  logic [3:0] din = 0;
  logic [2:0] sel = 0;
  logic [31:0] dq0, dq1;
  logic [23:0] dq2;
  logic [7:0] dv0, dv1;
  logic [5:0] dv2;
  logic [2:0] cc0, cc1, cc2;
  logic wr0, wr1, wr2, se0, se1, se2;
  int passed = 0, total = 0;
  int n_of[3] = '{8, 8, 6};
  int hold_of[3] = '{1, 0, 1};
  int mem[3][8];
  int ptr[3], cur[3], vld[3], wrp[3], err[3];

  always #5 clk = ~clk;

  demux_reg_n #(.W(4), .N(8), .SELW(3), .HOLD(1)) u0 (.clk(clk), .rst(rst), .din(din), .sel(sel), .en(en), .auto(auto),
    .dout(dq0), .dvalid(dv0), .cur_ch(cc0), .wrap(wr0), .sel_err(se0));
  demux_reg_n #(.W(4), .N(8), .SELW(3), .HOLD(0)) u1 (.clk(clk), .rst(rst), .din(din), .sel(sel), .en(en), .auto(auto),
    .dout(dq1), .dvalid(dv1), .cur_ch(cc1), .wrap(wr1), .sel_err(se1));
  demux_reg_n #(.W(4), .N(6), .SELW(3), .HOLD(1)) u2 (.clk(clk), .rst(rst), .din(din), .sel(sel), .en(en), .auto(auto),
    .dout(dq2), .dvalid(dv2), .cur_ch(cc2), .wrap(wr2), .sel_err(se2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) mem[i][k] = 0;
      ptr[i] = 0; cur[i] = 0; vld[i] = 0; wrp[i] = 0; err[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int t;
      t = -1;
      vld[i] = 0; wrp[i] = 0; err[i] = 0;
      if (en && auto) begin
        t = ptr[i];
        wrp[i] = (t == n_of[i] - 1);
        ptr[i] = (ptr[i] + 1) % n_of[i];
      end else if (en) begin
        if (int'(sel) < n_of[i]) t = sel;
        else err[i] = 1;
      end
      for (int k = 0; k < n_of[i]; k++) if (!hold_of[i]) mem[i][k] = 0;
      if (t >= 0) begin
        mem[i][t] = din;
        vld[i] = 1 << t;
        cur[i] = t;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ed;
      ed = 0;
      for (int k = 0; k < n_of[i]; k++) ed |= 32'(mem[i][k]) << (4 * k);
      chk($sformatf("%s.u%0d.dout", tag, i), i == 0 ? dq0 : i == 1 ? dq1 : {8'h0, dq2}, ed);
      chk($sformatf("%s.u%0d.dvalid", tag, i), i == 0 ? {24'h0, dv0} : i == 1 ? {24'h0, dv1} : {26'h0, dv2}, 32'(vld[i]));
      chk($sformatf("%s.u%0d.cur_ch", tag, i), {29'h0, i == 0 ? cc0 : i == 1 ? cc1 : cc2}, 32'(cur[i]));
      chk($sformatf("%s.u%0d.wrap", tag, i), {31'h0, i == 0 ? wr0 : i == 1 ? wr1 : wr2}, 32'(wrp[i]));
      chk($sformatf("%s.u%0d.sel_err", tag, i), {31'h0, i == 0 ? se0 : i == 1 ? se1 : se2}, 32'(err[i]));
    end
  endtask

  task automatic step(input string tag, input logic e, input logic a, input logic [2:0] s, input logic [3:0] d);
    @(negedge clk);
    en = e; auto = a; sel = s; din = d;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1;
    #1 model_reset();
    check_all(tag);
    #10 rst = 0;
  endtask

  initial begin
    model_reset();
    #3 check_all("por");
    #20 rst = 0;
    for (int k = 0; k < 8; k++) step("sweep", 1, 0, 3'(k), 4'h6);
    for (int k = 0; k < 8; k++) step("idle", 0, 0, 3'($urandom), 4'($urandom));
    mid_reset("rst1");
    step("first", 1, 0, 3'd2, 4'h9);
    for (int k = 1; k <= 9; k++) step("scan", 1, 1, 3'($urandom), 4'(k));
    step("err6", 1, 0, 3'd6, 4'hA);
    step("err7", 1, 0, 3'd7, 4'hB);
    step("sel5", 1, 0, 3'd5, 4'hC);
    mid_reset("rst2");
    for (int k = 0; k < 3; k++) step("ms_a", 1, 1, 3'd0, 4'(k + 3));
    step("ms_m", 1, 0, 3'd6, 4'hE);
    step("ms_m", 1, 0, 3'd6, 4'hF);
    for (int k = 0; k < 3; k++) step("ms_r", 1, 1, 3'd6, 4'(k + 7));
    mid_reset("rst3");
    step("ms_z", 1, 1, 3'd4, 4'hD);
    for (int k = 0; k < 400; k++) begin
      step("rnd", ($urandom % 4) != 0, $urandom % 2 == 1, 3'($urandom), 4'($urandom));
      if (k == 200) mid_reset("rst4");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
